// File: rtl/elastic_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// elastic_stage_reg_pkg
// Shared constants and types for the elastic pipeline stage register.
//   LEN_REG_ADDRESS / LEN_REGISTER : default destination-address and data widths
//   CTRL_MEM_READ / CTRL_WB_EN     : default bit positions inside the ctrl vector
//   buf_op_e                       : encoding of the per-cycle buffer operation
// -----------------------------------------------------------------------------
package elastic_stage_reg_pkg;

    localparam int LEN_REG_ADDRESS = 5;
    localparam int LEN_REGISTER    = 32;

    localparam int CTRL_MEM_READ   = 0;
    localparam int CTRL_WB_EN      = 1;

    // Encoded as {push, pop} so it can be cast directly from the two strobes.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } buf_op_e;

endpackage

// File: rtl/elastic_stage_reg_if.sv
// -----------------------------------------------------------------------------
// elastic_stage_reg_if
// Valid/ready bundle for the elastic stage register: upstream (in_*) and
// downstream (out_*) sides in one interface.
//   master : the surrounding pipeline (drives in_* payload and out_ready)
//   slave  : the stage register itself (drives in_ready and out_* payload)
// -----------------------------------------------------------------------------
interface elastic_stage_reg_if
    import elastic_stage_reg_pkg::*;
#(
    parameter int CTRL_W = 2,
    parameter int DEST_W = LEN_REG_ADDRESS,
    parameter int DATA_W = LEN_REGISTER
) ();

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DEST_W-1:0] in_dest;
    logic [DATA_W-1:0] in_data0;
    logic [DATA_W-1:0] in_data1;

    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DEST_W-1:0] out_dest;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;

    modport master (
        output in_valid, in_ctrl, in_dest, in_data0, in_data1, out_ready,
        input  in_ready, out_valid, out_ctrl, out_dest, out_data0, out_data1
    );

    modport slave (
        input  in_valid, in_ctrl, in_dest, in_data0, in_data1, out_ready,
        output in_ready, out_valid, out_ctrl, out_dest, out_data0, out_data1
    );

endinterface

// File: rtl/elastic_stage_reg_stage_buffer_mem.sv
// -----------------------------------------------------------------------------
// stage_buffer_mem
// DEPTH x WIDTH entry storage for the elastic stage register.
//   clk       : clock
//   rst       : synchronous active-low clear of every entry
//   wr_en_i   : write wr_data_i at wr_addr_i on the rising edge
//   wr_addr_i : write index
//   wr_data_i : write data
//   rd_addr_i : read index (asynchronous read)
//   rd_data_o : entry at rd_addr_i
// -----------------------------------------------------------------------------
module stage_buffer_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/elastic_stage_reg.sv
// -----------------------------------------------------------------------------
// elastic_stage_reg
// DEPTH-entry elastic pipeline stage register with valid/ready handshakes,
// synchronous flush and gating of the control bits on bubbles.
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-low reset (wins over flush)
//   flush : empties the buffer; a push or pop in the same cycle is ignored
//   bus   : upstream in_* / downstream out_* handshake and payload
//   count : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module elastic_stage_reg
    import elastic_stage_reg_pkg::*;
#(
    parameter int CTRL_W = 2,
    parameter int DEST_W = LEN_REG_ADDRESS,
    parameter int DATA_W = LEN_REGISTER,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    elastic_stage_reg_if.slave     bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = CTRL_W + DEST_W + 2 * DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push;
    logic             pop;
    buf_op_e          op;

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [CTRL_W-1:0]  rd_ctrl;
    logic [DEST_W-1:0]  rd_dest;
    logic [DATA_W-1:0]  rd_data0;
    logic [DATA_W-1:0]  rd_data1;

    // Ready depends on occupancy only: a full buffer never passes through,
    // which keeps in_ready a pure register output for the upstream stage.
    assign bus.in_ready  = (count_q < DEPTH_C);
    assign bus.out_valid = (count_q != '0);

    assign push = bus.in_valid  & bus.in_ready  & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;
    assign op   = buf_op_e'({push, pop});

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case (op)
                OP_PUSH: count_d = count_q + CNT_W'(1);
                OP_POP:  count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_entry = {bus.in_ctrl, bus.in_dest, bus.in_data0, bus.in_data1};

    stage_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_entry)
    );

    assign {rd_ctrl, rd_dest, rd_data0, rd_data1} = rd_entry;

    // A bubble must never look like a write-back or a load downstream.
    assign bus.out_ctrl  = rd_ctrl & {CTRL_W{bus.out_valid}};
    assign bus.out_dest  = rd_dest;
    assign bus.out_data0 = rd_data0;
    assign bus.out_data1 = rd_data1;

    assign count = count_q;

endmodule

// File: doc/elastic_stage_reg.md
# elastic_stage_reg

Parametrised, flow-controlled pipeline stage register for the MEM/WB boundary and any other inter-stage boundary. It replaces the fixed, freeze-gated stage register with a DEPTH-entry elastic buffer using valid/ready handshakes, a synchronous flush, and control-bit gating, so a stalled downstream stage no longer freezes the upstream pipeline. Payload is one control vector, one destination register address and two data words.

## Interface
- CTRL_W, default 2: control bits carried per entry; default bit 0 is mem_read, bit 1 is wb_enable.
- DEST_W, default `LEN_REG_ADDRESS: destination register address width.
- DATA_W, default `LEN_REGISTER: width of each data word.
- DEPTH, default 2: number of entries; a power of two, at least 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- flush  in  1  discards all stored entries and any same-cycle push.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  buffer can accept an entry.
- in_ctrl  in  CTRL_W  control bits.
- in_dest  in  DEST_W  destination register address.
- in_data0, in_data1  in  DATA_W each  payload words (ALU result, memory data).
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes the head entry.
- out_ctrl  out  CTRL_W  head control bits; forced to 0 when out_valid=0.
- out_dest, out_data0, out_data1  out  DEST_W / DATA_W  head payload.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Circular buffer with rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and a count register.
- Push = in_valid & in_ready & ~flush. The entry is written at wr_ptr, then wr_ptr advances.
- Pop = out_valid & out_ready & ~flush. rd_ptr advances.
- in_ready = (count < DEPTH). It is combinational from count only and does not depend on out_ready, so there is no full-buffer pass-through.
- out_valid = (count != 0). The head payload is read from storage at rd_ptr. There is no empty-buffer bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Full (count = DEPTH): in_ready = 0, so the upstream holds. A pop this cycle frees a slot, and in_ready rises the next cycle.
- Empty: out_valid = 0 and out_ctrl = 0. out_dest and out_data* show the stale entry at rd_ptr and are don't-care.
- Flush: next cycle count = 0 and rd_ptr = wr_ptr = 0. A push or pop in the flush cycle is ignored. Storage contents are retained.
- Control gating: out_ctrl = stored ctrl & {CTRL_W{out_valid}}. A bubble therefore never asserts wb_enable or mem_read.
- Reset (rst = 0 at a clock edge): pointers, count and all storage are cleared, and rst takes priority over flush.

## Timing
- Reset values: in_ready = 1, out_valid = 0, count = 0, and out_ctrl, out_dest and out_data* are all 0.
- Latency is 1 cycle: an entry pushed at edge N is visible with out_valid = 1 after edge N.
- Throughput is 1 entry per cycle when out_ready stays high. DEPTH = 2 sustains that rate with registered ready.
- Reset or flush mid-operation: all entries are lost at that edge; out_valid = 0 and in_ready = 1 from the next cycle.
- Order is strict FIFO. No entry is duplicated or dropped except by flush or reset.

## Structure
- `LEN_REG_ADDRESS and `LEN_REGISTER stay in ISA.v. Add default ctrl bit positions `CTRL_MEM_READ = 0 and `CTRL_WB_EN = 1 there.
- Sub-module stage_buffer_mem: DEPTH x (CTRL_W+DEST_W+2*DATA_W) storage.
  - Synchronous write, asynchronous read.
  - Synchronous active-low clear.
- The top level holds the pointers, count, handshake logic and control gating.

## Test plan
- Reset: hold rst = 0 for 2 cycles with in_valid = 1 -> count = 0, out_valid = 0, in_ready = 1, out_ctrl = 0. No entry is stored.
- Streaming: push dest 1..8 with data0 = 0x10..0x17 back to back, out_ready = 1 -> out_valid rises one cycle after the first push. Entries come out in order, one per cycle, and count never exceeds 1.
- Backpressure: out_ready = 0 and push 3 entries (DEPTH = 2) -> in_ready = 0 after the 2nd push and the 3rd is held. Raising out_ready -> outputs 1, 2, 3 in order, with no loss.
- Simultaneous push/pop at count = 1 -> count stays 1, the head advances, and wr_ptr wraps from 1 to 0 correctly.
- Flush while count = 2 with a concurrent push -> next cycle count = 0, out_valid = 0, out_ctrl = 0. The pushed entry never appears.
- Gating: store ctrl = 2'b11, pop it, leave the buffer empty -> out_ctrl = 0 while out_valid = 0. Repeat with DEPTH = 4, DATA_W = 64 for the full/wrap checks.
